bcd_serial_addsub: RTL and testbench
====================================

Name: bcd_serial_addsub

Overview:
- Parametrised successor to the two-digit combinational BCD adder used on the DE2-115 board.
- Adds or subtracts two DIGITS-wide packed-BCD operands digit-serially, least significant digit first, one digit per clock.
- Uses a start/done handshake, holds the registered result, and drives active-low seven-segment patterns for both operands and the result.
- Sits between switch/key input logic and the HEX displays. It also serves as the arithmetic core for later counter and calculator labs.

Parameters:
- DIGITS, 2, number of BCD digits per operand (legal range 1..8).

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request pulse; sampled only in IDLE.
- Sub  in  1  0 = add, 1 = subtract (A − B); sampled with Start.
- Ci  in  1  carry-in for add; ignored when Sub = 1; sampled with Start.
- A  in  4*DIGITS  operand A, packed BCD, digit 0 in [3:0].
- B  in  4*DIGITS  operand B, packed BCD.
- Busy  out  1  high while an operation is in progress.
- Done  out  1  one-cycle pulse when Result and Co update.
- Result  out  4*DIGITS  registered BCD result.
- Co  out  1  add: decimal carry-out; sub: 1 = no borrow (A ≥ B).
- LEDA  out  7*DIGITS  seven-segment patterns for the latched A.
- LEDB  out  7*DIGITS  seven-segment patterns for the latched B.
- LEDs  out  7*(DIGITS+1)  patterns for Result; the top digit shows Co as 0/1.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - Busy = 0, Done = 0, Result = 0, Co = 0.
  - Operand latches are cleared to 0.
  - All displays therefore show "0". Segment encoding is active-low, seg[0] = a … seg[6] = g; "0" = 7'b1000000.
- State IDLE:
  - If Start = 1: latch A, B, Sub and the initial carry, clear the digit index to 0, and go to RUN.
  - Initial carry is Ci when Sub = 0, and 1 when Sub = 1.
- State RUN (one digit per cycle, index i):
  - b' = B[i] when adding; b' = 9 − B[i] (nines complement) when subtracting.
  - t = A[i] + b' + c, computed 5 bits wide.
  - If t > 9: digit = t − 10 and c = 1. Otherwise digit = t[3:0] and c = 0.
  - The digit is written into a working register at position i.
  - After digit DIGITS−1 is processed, go to DONE.
- State DONE (one cycle):
  - Copy the working register to Result and the final carry to Co.
  - Done = 1 for this cycle only.
  - Return to IDLE.
- Latency: Start seen in IDLE at cycle n → Done high at cycle n+DIGITS+1.
- Busy is high in RUN and DONE.
- Start is ignored while Busy = 1. There is no queueing.
- Result and Co hold their previous values throughout RUN and change only in the DONE cycle.
- Changes to A, B, Sub or Ci after they are latched have no effect on the operation in progress.
- LEDA and LEDB reflect the latched operands, not the live inputs.
- Subtraction with A < B: Result is the ten's complement (for example 23 − 50 → 73) with Co = 0. No sign display.
- Non-BCD input digits (values 10..15) without the optional feature: the arithmetic rule above is applied as written and the result is unspecified but deterministic. The display shows blank (7'b1111111) for any nibble greater than 9.
- Reset asserted mid-operation: the operation is aborted on that edge and all outputs return to their reset values. Done is never pulsed for the aborted operation.
- Start and Reset high together: Reset wins.

Optional Feature:
- Macro: BCD_CHECK_EN.
- When defined:
  - Adds output port Err (1 bit, reset 0).
  - In IDLE, if Start = 1 and any nibble of A or B is greater than 9, the block does not enter RUN. Instead it goes directly to DONE with Result = 0, Co = 0 and Err = 1.
  - Latency for this rejection is 1 cycle, then Done pulses.
  - Err holds its value until the next accepted Start, which clears it.
- When undefined: there is no Err port and no input check. Behaviour is as described under Behaviour.

Test Plan:
- DIGITS=2, add 45+37, Ci=0, Start pulse → Done on the 3rd cycle after Start; Result = 0x82, Co = 0; LEDs show 0 8 2.
- Add 99+99, Ci=1 → Result = 0x99, Co = 1; top display shows "1".
- Sub 50−23 → Result = 0x27, Co = 1. Sub 23−50 → Result = 0x73, Co = 0.
- Start re-pulsed while Busy, and A changed mid-run → the first result is unaffected; exactly one Done pulse.
- Reset asserted during the second RUN cycle → next edge: Busy = 0, Result = 0, LEDs all "0", no Done pulse.
- With BCD_CHECK_EN: A=0x1A, B=0x05, Start → Done one cycle later; Err = 1, Result = 0x00. A following valid Start clears Err.

Source files
------------

// File: rtl/bcd_serial_addsub_if.sv
// Bus interface for bcd_serial_addsub: operands and start/done handshake,
// registered result and active-low seven-segment display patterns.
// When BCD_CHECK_EN is defined, the interface also carries the err flag
// raised for non-BCD operands.
interface bcd_serial_addsub_if #(
    parameter int DIGITS = 2
);
    logic                    start;
    logic                    sub;
    logic                    ci;
    logic [4*DIGITS-1:0]     a;
    logic [4*DIGITS-1:0]     b;
    logic                    busy;
    logic                    done;
    logic [4*DIGITS-1:0]     result;
    logic                    co;
    logic [7*DIGITS-1:0]     leda;
    logic [7*DIGITS-1:0]     ledb;
    logic [7*(DIGITS+1)-1:0] leds;
`ifdef BCD_CHECK_EN
    logic                    err;

    modport master (output start, sub, ci, a, b,
                    input  busy, done, result, co, leda, ledb, leds, err);
    modport slave  (input  start, sub, ci, a, b,
                    output busy, done, result, co, leda, ledb, leds, err);
`else
    modport master (output start, sub, ci, a, b,
                    input  busy, done, result, co, leda, ledb, leds);
    modport slave  (input  start, sub, ci, a, b,
                    output busy, done, result, co, leda, ledb, leds);
`endif
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, least significant digit first,
// one digit per clock, with a start/done handshake and seven-segment
// patterns (active-low, bit0 = a .. bit6 = g) for the latched operands
// and the result. Subtraction is A + nines-complement(B) + 1.
// Optional feature macro: BCD_CHECK_EN (adds err and rejects non-BCD inputs).
module bcd_serial_addsub #(
    parameter int DIGITS = 2
) (
    input logic                clk,
    input logic                rst,
    bcd_serial_addsub_if.slave bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [W-1:0]     a_q, b_q, work, result;
    logic             sub_q, carry, co, busy, done;
    logic [IDX_W-1:0] idx;
`ifdef BCD_CHECK_EN
    logic             err;
`endif

    logic [3:0]       a_dig, b_dig, b_eff, sum_dig;
    logic [4:0]       t;
    logic             carry_next;
    logic [W-1:0]     work_next;

    // Active-low segment pattern; anything above 9 is blanked.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

`ifdef BCD_CHECK_EN
    // True when every nibble of v is a legal decimal digit.
    function automatic logic all_bcd(input logic [W-1:0] v);
        all_bcd = 1'b1;
        for (int k = 0; k < DIGITS; k++)
            if (v[4*k +: 4] > 4'd9) all_bcd = 1'b0;
    endfunction
`endif

    // One decimal digit step: select digit idx, add with carry, correct by 10.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                a_dig = a_q[4*k +: 4];
                b_dig = b_q[4*k +: 4];
            end
        end
        b_eff = sub_q ? (4'd9 - b_dig) : b_dig;
        t     = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry};
        if (t > 5'd9) begin
            sum_dig    = 4'(t - 5'd10);
            carry_next = 1'b1;
        end else begin
            sum_dig    = t[3:0];
            carry_next = 1'b0;
        end
        work_next = work;
        for (int k = 0; k < DIGITS; k++)
            if (idx == IDX_W'(k)) work_next[4*k +: 4] = sum_dig;
    end

    // Control FSM: latch operands on start, step digits, publish result with a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            co     <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            work   <= '0;
`ifdef BCD_CHECK_EN
            err    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        sub_q <= bus.sub;
                        // Subtraction needs the +1 of the ten's complement.
                        carry <= bus.sub | bus.ci;
                        idx   <= '0;
                        work  <= '0;
                        busy  <= 1'b1;
`ifdef BCD_CHECK_EN
                        if (!all_bcd(bus.a) || !all_bcd(bus.b)) begin
                            state  <= DONE;
                            result <= '0;
                            co     <= 1'b0;
                            err    <= 1'b1;
                            done   <= 1'b1;
                        end else begin
                            state <= RUN;
                            err   <= 1'b0;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    work  <= work_next;
                    carry <= carry_next;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        state  <= DONE;
                        result <= work_next;
                        co     <= carry_next;
                        done   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result;
    assign bus.co     = co;
`ifdef BCD_CHECK_EN
    assign bus.err    = err;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        assign bus.leda[7*g +: 7] = seg7(a_q[4*g +: 4]);
        assign bus.ledb[7*g +: 7] = seg7(b_q[4*g +: 4]);
        assign bus.leds[7*g +: 7] = seg7(result[4*g +: 4]);
    end
    // Extra top display shows the carry / no-borrow flag as 0 or 1.
    assign bus.leds[7*DIGITS +: 7] = co ? seg7(4'd1) : seg7(4'd0);

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed, table-driven bench for bcd_serial_addsub with DIGITS = 2.
module tb_bcd_serial_addsub;
    localparam int DIGITS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_serial_addsub_if #(.DIGITS(DIGITS)) bus ();
    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       ci;
        logic [7:0] res;
        logic       co;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    function automatic logic [20:0] leds_of(input logic [7:0] r, input logic c);
        leds_of = {seg({3'b000, c}), seg(r[7:4]), seg(r[3:0])};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic ci);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.ci    = ci;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Edges after the start-sampling edge until done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int pulses;
        logic [7:0] res_seen;
        logic co_seen;

        vecs[0] = '{a: 8'h45, b: 8'h37, sub: 1'b0, ci: 1'b0, res: 8'h82, co: 1'b0};
        vecs[1] = '{a: 8'h99, b: 8'h99, sub: 1'b0, ci: 1'b1, res: 8'h99, co: 1'b1};
        vecs[2] = '{a: 8'h50, b: 8'h23, sub: 1'b1, ci: 1'b0, res: 8'h27, co: 1'b1};
        vecs[3] = '{a: 8'h23, b: 8'h50, sub: 1'b1, ci: 1'b0, res: 8'h73, co: 1'b0};
        vecs[4] = '{a: 8'h00, b: 8'h00, sub: 1'b0, ci: 1'b1, res: 8'h01, co: 1'b0};
        vecs[5] = '{a: 8'h34, b: 8'h34, sub: 1'b1, ci: 1'b0, res: 8'h00, co: 1'b1};
        vecs[6] = '{a: 8'h05, b: 8'h95, sub: 1'b0, ci: 1'b0, res: 8'h00, co: 1'b1};
        vecs[7] = '{a: 8'h10, b: 8'h01, sub: 1'b1, ci: 1'b1, res: 8'h09, co: 1'b1};
        vecs[8] = '{a: 8'h00, b: 8'h01, sub: 1'b1, ci: 1'b0, res: 8'h99, co: 1'b0};

        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.ci    = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", 32'(bus.result), 32'h00);
        check("reset_co", 32'(bus.co), 32'd0);
        check("reset_leds", 32'(bus.leds), 32'(21'b1000000_1000000_1000000));
        check("reset_leda", 32'(bus.leda), 32'(14'b1000000_1000000));
        @(negedge clk);
        rst = 1'b0;

        // Table-driven operations
        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].ci);
            check($sformatf("v%0d_busy_run", i), 32'(bus.busy), 32'd1);
            wait_done(lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(DIGITS));
            check($sformatf("v%0d_result", i), 32'(bus.result), 32'(vecs[i].res));
            check($sformatf("v%0d_co", i), 32'(bus.co), 32'(vecs[i].co));
            check($sformatf("v%0d_leds", i), 32'(bus.leds), 32'(leds_of(vecs[i].res, vecs[i].co)));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_drop", i), 32'(bus.done), 32'd0);
            check($sformatf("v%0d_busy_drop", i), 32'(bus.busy), 32'd0);
        end

        // Hand check of 45+37 display: 0 8 2
        check("leds_082", 32'(leds_of(8'h82, 1'b0)), 32'(21'b1000000_0000000_0100100));

        // Start re-pulsed while busy and operands changed mid-run
        start_op(8'h45, 8'h37, 1'b0, 1'b0);
        bus.start = 1'b1;
        bus.a     = 8'h11;
        bus.b     = 8'h11;
        pulses    = 0;
        res_seen  = 8'h00;
        co_seen   = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                check("hold_result_in_run", 32'(bus.result), 32'h99);
                check("leda_latched", 32'(bus.leda), 32'({seg(4'd4), seg(4'd5)}));
                check("ledb_latched", 32'(bus.ledb), 32'({seg(4'd3), seg(4'd7)}));
            end
            if (bus.done) begin
                pulses++;
                res_seen = bus.result;
                co_seen  = bus.co;
            end
            if (c == 3) bus.start = 1'b0;
        end
        check("busy_done_pulses", 32'(pulses), 32'd1);
        check("busy_result", 32'(res_seen), 32'h82);
        check("busy_co", 32'(co_seen), 32'd0);

`ifdef BCD_CHECK_EN
        // Non-BCD operand rejected in one cycle
        start_op(8'h1A, 8'h05, 1'b0, 1'b0);
        check("bcd_done", 32'(bus.done), 32'd1);
        check("bcd_err", 32'(bus.err), 32'd1);
        check("bcd_result", 32'(bus.result), 32'h00);
        check("bcd_co", 32'(bus.co), 32'd0);
        @(posedge clk);
        #1;
        check("bcd_err_hold", 32'(bus.err), 32'd1);
        check("bcd_done_drop", 32'(bus.done), 32'd0);
        start_op(8'h01, 8'h02, 1'b0, 1'b0);
        check("bcd_err_clear", 32'(bus.err), 32'd0);
        wait_done(lat);
        check("bcd_after_result", 32'(bus.result), 32'h03);
        @(posedge clk);
`endif

        // Reset asserted during the second RUN cycle aborts the operation
        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", 32'(bus.result), 32'h00);
        check("abort_co", 32'(bus.co), 32'd0);
        check("abort_leds", 32'(bus.leds), 32'(21'b1000000_1000000_1000000));
        check("abort_leda", 32'(bus.leda), 32'(14'b1000000_1000000));
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);

        // Reset and start together: reset wins
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'h55;
        @(posedge clk);
        #1;
        check("rst_start_busy", 32'(bus.busy), 32'd0);
        check("rst_start_leda", 32'(bus.leda), 32'(14'b1000000_1000000));
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_start_idle", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
